mvm_row_loader: RTL

- Upstream fill stage for the MVM datapath.
- Fetches NUM_MAC+1 64-bit rows from the Avalon-style ROM (mem_wrapper protocol: read/waitrequest/readdatavalid).
- Serializes each row byte-by-byte, LSB first, into the vector-B FIFO (row 0) and the matrix-A FIFOs (rows 1..NUM_MAC).
- Replaces ad-hoc fill logic inside the MVM with a clean handshaked loader that signals completion so the MVM can enter execution.

---
 rtl/mvm_pkg.sv | 22 ++
 rtl/mvm_row_serializer.sv | 54 +++++
 rtl/mvm_row_loader.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mvm_pkg.sv
// Shared types and constants for the MVM fill path: loader FSM states and
// row/byte geometry used by the row loader and its serializer.
package mvm_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } loader_state_t;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int WORD_WIDTH_DEF = 64;
    localparam int BYTES_PER_ROW  = WORD_WIDTH_DEF / DATA_WIDTH_DEF;
    localparam int B_ROW          = 0;

    function automatic int bytes_per_row(input int word_width, input int data_width);
        return word_width / data_width;
    endfunction

endpackage

// File: rtl/mvm_row_serializer.sv
// Holds one fetched row and emits it byte by byte, LSB first, advancing only
// when the destination FIFO can accept the byte.
module mvm_row_serializer
    import mvm_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int WORD_WIDTH = WORD_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [WORD_WIDTH-1:0] row_i,
    input  logic                  shift_en_i,
    input  logic                  full_i,
    output logic [DATA_WIDTH-1:0] byte_o,
    output logic                  fire_o,
    output logic                  last_byte_o
);

    localparam int BPR   = bytes_per_row(WORD_WIDTH, DATA_WIDTH);
    localparam int CNT_W = (BPR > 1) ? $clog2(BPR) : 1;

    logic [WORD_WIDTH-1:0] row_buf_q, row_buf_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  at_last;

    assign at_last     = (cnt_q == CNT_W'(BPR - 1));
    assign fire_o      = shift_en_i && !full_i;
    assign last_byte_o = fire_o && at_last;
    assign byte_o      = row_buf_q[cnt_q*DATA_WIDTH +: DATA_WIDTH];

    // A full destination simply withholds fire_o, so the counter holds the byte.
    always_comb begin
        row_buf_d = row_buf_q;
        cnt_d     = cnt_q;
        if (load_i) begin
            row_buf_d = row_i;
            cnt_d     = '0;
        end else if (fire_o) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            row_buf_q <= '0;
            cnt_q     <= '0;
        end else begin
            row_buf_q <= row_buf_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/mvm_row_loader.sv
// Fetches NUM_MAC+1 rows from the ROM and streams them bytewise into the
// vector-B FIFO (row 0) and matrix-A FIFOs (rows 1..NUM_MAC), then pulses done.
module mvm_row_loader
    import mvm_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_MAC    = 8,
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    input  logic [WORD_WIDTH-1:0] mem_readdata,
    input  logic                  mem_readdatavalid,
    input  logic                  mem_waitrequest,
    output logic                  b_wren,
    input  logic                  b_full,
    output logic [NUM_MAC-1:0]    a_wren,
    input  logic [NUM_MAC-1:0]    a_full,
    output logic [DATA_WIDTH-1:0] wr_data,
    output loader_state_t         dbg_state
);

    localparam int ROW_W = $clog2(NUM_MAC + 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_MAC);

    // Memory handshake: a request is accepted in a cycle with mem_read=1 and
    // mem_waitrequest=0; mem_readdata is only trusted with mem_readdatavalid in WAIT.
    loader_state_t         state_q, state_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [NUM_MAC-1:0]    a_sel;
    logic                  is_b;
    logic                  dest_full;
    logic                  load;
    logic                  shift_en;
    logic                  fire;
    logic                  row_last;
    logic [DATA_WIDTH-1:0] ser_byte;

    always_comb begin
        a_sel = '0;
        for (int i = 0; i < NUM_MAC; i++) begin
            if (row_q == ROW_W'(i + 1)) a_sel[i] = 1'b1;
        end
    end

    assign is_b      = (row_q == ROW_W'(B_ROW));
    assign dest_full = is_b ? b_full : |(a_full & a_sel);
    assign load      = (state_q == WAIT) && mem_readdatavalid;
    assign shift_en  = (state_q == SHIFT);

    mvm_row_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_serializer (
        .clk_i       (clk),
        .rst_i       (rst),
        .load_i      (load),
        .row_i       (mem_readdata),
        .shift_en_i  (shift_en),
        .full_i      (dest_full),
        .byte_o      (ser_byte),
        .fire_o      (fire),
        .last_byte_o (row_last)
    );

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    row_d   = '0;
                end
            end
            REQ: begin
                if (!mem_waitrequest) state_d = WAIT;
            end
            WAIT: begin
                if (mem_readdatavalid) state_d = SHIFT;
            end
            SHIFT: begin
                if (row_last) begin
                    if (row_q == LAST_ROW) begin
                        state_d = DONE;
                        row_d   = '0;
                    end else begin
                        state_d = REQ;
                        row_d   = row_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                row_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    assign busy        = (state_q == REQ) || (state_q == WAIT) || (state_q == SHIFT);
    assign done        = (state_q == DONE);
    assign mem_read    = (state_q == REQ);
    assign mem_address = ADDR_WIDTH'(row_q);
    assign b_wren      = fire && is_b;
    assign a_wren      = fire ? a_sel : '0;
    assign wr_data     = shift_en ? ser_byte : '0;
    assign dbg_state   = state_q;

endmodule
